isq_lin_gen: RTL
================

# isq_lin_gen

Instruction-slot-queue line generator for the rename stage; it is the producer side of the ISQ line interface that the TPU line renamer consumes. It accepts decoded instructions, allocates a physical destination register from a free list, buffers them in a 2^ISQ_IDX_BITS_NUM-entry circular queue, and presents the head entry as one packed ISQ line per cycle. Physical registers released at commit return to the free list.

## Interface
- INST_WIDTH, 22, instruction field width of a line, excluding the index.
- ISQ_IDX_BITS_NUM, 2, slot index width; queue depth is 2^ISQ_IDX_BITS_NUM.
- PREG_NUM, 64, number of physical registers; 6-bit register IDs.
- LREG_NUM, 16, number of logical registers; 4-bit register IDs.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dec_vld  in  1  decoded instruction present.
- dec_rdy  out  1  queue can accept this cycle.
- dec_src1_vld / dec_src1  in  1 / 4  source 1 used / logical ID.
- dec_src2_vld / dec_src2  in  1 / 4  source 2 used / logical ID.
- dec_dst_vld / dec_dst  in  1 / 4  destination used / logical ID.
- isq_lin  out  INST_WIDTH+ISQ_IDX_BITS_NUM  head line, packed MSB→LSB as {idx, vld, src1_vld, src1[3:0], dst_vld, dst[3:0], src2_vld, src2[3:0], pdst[5:0]}.
- isq_pop  in  1  consumer took the head line this cycle.
- free_vld / free_preg  in  1 / 6  commit releases a physical register.
- fl_cnt  out  7  free-list occupancy.

## Operation
- Reset: queue empty; head/tail pointers = 0; free list holds pregs LREG_NUM..PREG_NUM-1 (16..63) in ascending pop order; fl_cnt = 48. Outputs after reset: isq_lin = 0 (vld = 0), dec_rdy = 1, fl_cnt = 48.
- dec_rdy = !full && (fl_cnt != 0). This uses registered state only, so there is no combinational path from dec_vld.
- Enqueue occurs on dec_vld && dec_rdy. The entry is written at the tail with idx = tail slot number.
  - If dec_dst_vld, pdst = free-list head, and the free list pops.
  - If not dec_dst_vld, pdst = 0 and no pop.
- Output is the head entry with vld = 1 when the queue is non-empty; otherwise isq_lin is all zero.
- Dequeue occurs on isq_pop && !empty; the head advances. isq_pop while empty is ignored.
- The free list is a 64-entry circular FIFO.
  - On free_vld, free_preg is pushed.
  - A push and a pop in the same cycle leave fl_cnt unchanged; both pointers advance.
  - A push when fl_cnt = 64 is dropped.
- Pointers wrap modulo depth. full/empty are derived from an occupancy counter of width ISQ_IDX_BITS_NUM+1.

## Timing
- Enqueue-to-output latency is 1 cycle: a line accepted at edge N is visible on isq_lin after edge N if the queue was empty.
- Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance.
- Full queue with isq_pop: dec_rdy stays 0 in that cycle, because there is no same-cycle refill. The slot is usable from the next cycle.
- Free list empty with free_vld in the same cycle: dec_rdy stays 0. The freed register is allocatable next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). In-flight entries and allocations are discarded, and the free list is reinitialised to 16..63.

## Configuration
- ISQ_BYPASS_EN defined: when the queue is empty and dec_vld && dec_rdy, the incoming line appears combinationally on isq_lin in the same cycle.
  - If isq_pop is also high, the instruction is not stored and the free-list pop still occurs.
  - If isq_pop is low, the instruction is enqueued normally.
- ISQ_BYPASS_EN undefined: latency is strictly 1 cycle as specified above.

## Test plan
- Reset, then idle → isq_lin = 0, dec_rdy = 1, fl_cnt = 48.
- Enqueue src1 = 0, dst = 2, src2 = 1, all valid, isq_pop = 0 → next cycle isq_lin = {2'b00, 1, 1, 0000, 1, 0010, 1, 0001, 6'd16}, fl_cnt = 47.
- Five back-to-back enqueues with no pop → four accepted with idx 0..3 and pdst 16..19; dec_rdy = 0 after the fourth; pop once → dec_rdy = 1 the following cycle, and the next line gets idx 0 (wrap).
- Enqueue with dec_dst_vld = 0 → pdst = 0, fl_cnt unchanged.
- Drain the free list with 48 dst allocations (popping lines continuously) → dec_rdy = 0 at fl_cnt = 0; free_vld with preg 5 → dec_rdy = 1 next cycle, and the next allocation gets pdst = 5.
- Simultaneous free_vld and a dst enqueue → fl_cnt unchanged. Assert rst_n low mid-stream → isq_lin = 0 and fl_cnt = 48 immediately. With ISQ_BYPASS_EN, enqueue into an empty queue with isq_pop = 1 → line visible the same cycle and the queue stays empty.

Source files
------------

// File: rtl/isq_lin_gen_if.sv
// ---------------------------------------------------------------------------
// isq_lin_gen_if
// Bundle of the decode-side, ISQ-line-side and commit-side signals of the
// ISQ line generator.
//   master : the environment. It drives decoded instructions, consumer pops
//            and commit frees, and observes dec_rdy, isq_lin and fl_cnt.
//   slave  : the generator (isq_lin_gen).
// Signals:
//   dec_vld, dec_rdy                decode handshake
//   dec_src1_vld/dec_src1           source 1 used / logical ID
//   dec_src2_vld/dec_src2           source 2 used / logical ID
//   dec_dst_vld/dec_dst             destination used / logical ID
//   isq_lin                         packed head line
//   isq_pop                         consumer took the head line
//   free_vld/free_preg              commit releases a physical register
//   fl_cnt                          free-list occupancy
// ---------------------------------------------------------------------------
interface isq_lin_gen_if #(
  parameter int INST_WIDTH       = 22,
  parameter int ISQ_IDX_BITS_NUM = 2
);
  logic                                   dec_vld;
  logic                                   dec_rdy;
  logic                                   dec_src1_vld;
  logic [3:0]                             dec_src1;
  logic                                   dec_src2_vld;
  logic [3:0]                             dec_src2;
  logic                                   dec_dst_vld;
  logic [3:0]                             dec_dst;
  logic [INST_WIDTH+ISQ_IDX_BITS_NUM-1:0] isq_lin;
  logic                                   isq_pop;
  logic                                   free_vld;
  logic [5:0]                             free_preg;
  logic [6:0]                             fl_cnt;

  modport master (
    output dec_vld, dec_src1_vld, dec_src1, dec_src2_vld, dec_src2,
           dec_dst_vld, dec_dst, isq_pop, free_vld, free_preg,
    input  dec_rdy, isq_lin, fl_cnt
  );

  modport slave (
    input  dec_vld, dec_src1_vld, dec_src1, dec_src2_vld, dec_src2,
           dec_dst_vld, dec_dst, isq_pop, free_vld, free_preg,
    output dec_rdy, isq_lin, fl_cnt
  );
endinterface

// File: rtl/isq_lin_gen.sv
// ---------------------------------------------------------------------------
// isq_lin_gen
// Rename-stage ISQ line generator. It accepts decoded instructions and
// allocates a physical destination register from a circular free list. It
// buffers the instructions in a 2^ISQ_IDX_BITS_NUM-entry circular queue and
// presents the head entry as one packed line per cycle. Registers released
// at commit are pushed back into the free list.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    isq_lin_gen_if.slave (decode handshake, isq_lin/isq_pop,
//          free_vld/free_preg, fl_cnt)
// Line format, MSB to LSB:
//   {idx, vld, src1_vld, src1, dst_vld, dst, src2_vld, src2, pdst}
// Optional feature:
//   ISQ_BYPASS_EN - an instruction accepted into an empty queue appears on
//   isq_lin in the same cycle. If it is also popped in that cycle, it is
//   never stored.
// ---------------------------------------------------------------------------
module isq_lin_gen #(
  parameter int INST_WIDTH       = 22,
  parameter int ISQ_IDX_BITS_NUM = 2,
  parameter int PREG_NUM         = 64,
  parameter int LREG_NUM         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  isq_lin_gen_if.slave bus
);
  localparam int DEPTH   = 1 << ISQ_IDX_BITS_NUM;
  localparam int ENT_W   = INST_WIDTH - 1;          // stored line without vld/idx
  localparam int LINE_W  = INST_WIDTH + ISQ_IDX_BITS_NUM;
  localparam int CNT_W   = ISQ_IDX_BITS_NUM + 1;
  localparam int PREG_W  = $clog2(PREG_NUM);
  localparam int FLCNT_W = PREG_W + 1;

  localparam logic [ISQ_IDX_BITS_NUM-1:0] PTR_ONE  = ISQ_IDX_BITS_NUM'(1);
  localparam logic [CNT_W-1:0]            CNT_ONE  = CNT_W'(1);
  localparam logic [PREG_W-1:0]           FPTR_ONE = PREG_W'(1);
  localparam logic [FLCNT_W-1:0]          FCNT_ONE = FLCNT_W'(1);

  // Instruction queue state
  logic [ENT_W-1:0]            q_mem_r [DEPTH];
  logic [ISQ_IDX_BITS_NUM-1:0] head_r;
  logic [ISQ_IDX_BITS_NUM-1:0] tail_r;
  logic [CNT_W-1:0]            q_cnt_r;

  // Free-list state
  logic [PREG_W-1:0]           fl_mem_r [PREG_NUM];
  logic [PREG_W-1:0]           fl_rd_r;
  logic [PREG_W-1:0]           fl_wr_r;
  logic [FLCNT_W-1:0]          fl_cnt_r;

  // Control
  logic                        empty_s;
  logic                        full_s;
  logic                        fl_empty_s;
  logic                        fl_full_s;
  logic                        rdy_s;
  logic                        enq_s;
  logic                        byp_s;
  logic                        wr_s;
  logic                        rd_s;
  logic                        fl_pop_s;
  logic                        fl_push_s;
  logic [PREG_W-1:0]           pdst_s;
  logic [ENT_W-1:0]            new_ent_s;
  logic [LINE_W-1:0]           line_s;

  // Handshake, allocation and queue read/write controls
  always_comb begin
    empty_s    = (q_cnt_r == CNT_W'(0));
    full_s     = (q_cnt_r == CNT_W'(DEPTH));
    fl_empty_s = (fl_cnt_r == FLCNT_W'(0));
    fl_full_s  = (fl_cnt_r == FLCNT_W'(PREG_NUM));
    // Depends only on registered state: a register freed this cycle is
    // not allocatable until the next one.
    rdy_s      = !full_s && !fl_empty_s;
    enq_s      = bus.dec_vld && rdy_s;
    fl_pop_s   = enq_s && bus.dec_dst_vld;
    fl_push_s  = bus.free_vld && !fl_full_s;
    if (fl_pop_s) begin
      pdst_s = fl_mem_r[fl_rd_r];
    end else begin
      pdst_s = {PREG_W{1'b0}};
    end
    new_ent_s  = {bus.dec_src1_vld, bus.dec_src1, bus.dec_dst_vld, bus.dec_dst,
                  bus.dec_src2_vld, bus.dec_src2, pdst_s};
`ifdef ISQ_BYPASS_EN
    byp_s      = empty_s && enq_s;
`else
    byp_s      = 1'b0;
`endif
    // A bypassed line consumed in the same cycle never touches the queue.
    wr_s       = enq_s && !(byp_s && bus.isq_pop);
    rd_s       = bus.isq_pop && !empty_s;
  end

  // Head line selection: stored head, bypassed input, or all-zero idle line
  always_comb begin
    if (!empty_s) begin
      line_s = {head_r, 1'b1, q_mem_r[head_r]};
    end else if (byp_s) begin
      line_s = {tail_r, 1'b1, new_ent_s};
    end else begin
      line_s = {LINE_W{1'b0}};
    end
  end

  assign bus.isq_lin = line_s;
  assign bus.dec_rdy = rdy_s;
  assign bus.fl_cnt  = 7'(fl_cnt_r);

  // Instruction queue: storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {ISQ_IDX_BITS_NUM{1'b0}};
      tail_r  <= {ISQ_IDX_BITS_NUM{1'b0}};
      q_cnt_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_mem_r[i] <= {ENT_W{1'b0}};
      end
    end else begin
      if (wr_s) begin
        q_mem_r[tail_r] <= new_ent_s;
        tail_r          <= tail_r + PTR_ONE;
      end
      if (rd_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({wr_s, rd_s})
        2'b10:   q_cnt_r <= q_cnt_r + CNT_ONE;
        2'b01:   q_cnt_r <= q_cnt_r - CNT_ONE;
        default: q_cnt_r <= q_cnt_r;
      endcase
    end
  end

  // Free list: circular FIFO of physical register IDs, reset to LREG_NUM..PREG_NUM-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_rd_r  <= {PREG_W{1'b0}};
      fl_wr_r  <= PREG_W'(PREG_NUM - LREG_NUM);
      fl_cnt_r <= FLCNT_W'(PREG_NUM - LREG_NUM);
      for (int i = 0; i < PREG_NUM; i++) begin
        if (i < PREG_NUM - LREG_NUM) begin
          fl_mem_r[i] <= PREG_W'(i + LREG_NUM);
        end else begin
          fl_mem_r[i] <= {PREG_W{1'b0}};
        end
      end
    end else begin
      if (fl_pop_s) begin
        fl_rd_r <= fl_rd_r + FPTR_ONE;
      end
      if (fl_push_s) begin
        fl_mem_r[fl_wr_r] <= bus.free_preg;
        fl_wr_r           <= fl_wr_r + FPTR_ONE;
      end
      case ({fl_push_s, fl_pop_s})
        2'b10:   fl_cnt_r <= fl_cnt_r + FCNT_ONE;
        2'b01:   fl_cnt_r <= fl_cnt_r - FCNT_ONE;
        default: fl_cnt_r <= fl_cnt_r;
      endcase
    end
  end
endmodule
